// File: rtl/muldiv_sequencer.sv
// Purpose : sequential HI/LO multiply/divide unit (MULT, DIV, DIVU) with MFHI/MFLO read port.
// Latency : MULT busy MultCycles cycles, DIV/DIVU busy 33 cycles, divide-by-zero busy 1 cycle.
// Backpr. : Stall = Busy & (ReadReq | Start [| WriteReq]); held requests are honoured on the first IDLE cycle.
//
// Ports:
//   Clock, Reset     - rising-edge clock, asynchronous active-high reset
//   Start, Op, A, B  - launch request; Op 00 MULT, 01 DIV, 10 DIVU, 11 ignored; operands latched on accept
//   ReadReq, ReadSel - MFHI/MFLO request, ReadSel 1 = HI, 0 = LO
//   ReadData         - combinational view of HI or LO (pre-operation values while Busy)
//   Busy, Stall      - unit not idle / pipeline freeze request
//   DivZero          - one-cycle pulse when a divide by zero completes
//   WriteReq, WriteSel, WriteData - MTHI/MTLO port, present only when MULDIV_MTHI_EN is defined
module muldiv_sequencer #(
  parameter int MultCycles = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadReq,
  input  logic        ReadSel,
`ifdef MULDIV_MTHI_EN
  input  logic        WriteReq,
  input  logic        WriteSel,
  input  logic [31:0] WriteData,
`endif
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Stall,
  output logic        DivZero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [4:0] MulLast = 5'(MultCycles - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;      // divisor (magnitude for DIV)
  logic        dz_q, dz_d;        // current divide has a zero divisor
  logic        div_zero_q, div_zero_d;

  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod;
  logic [32:0] rem_sh;
  logic        sub_ok;

  assign accept = Start && (state_q == S_IDLE) && (Op != OP_RSVD);

  // DIV works on magnitudes; DIVU passes raw operands through.
  assign a_mag = ((Op == OP_DIV) && A[31]) ? (-A) : A;
  assign b_mag = ((Op == OP_DIV) && B[31]) ? (-B) : B;

  assign prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

  // Restoring step: remainder always stays below the divisor, so when the
  // trial subtraction succeeds the 32-bit modular difference is exact.
  assign rem_sh = {rem_q, quo_q[31]};
  assign sub_ok = (rem_sh >= {1'b0, dvs_q});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dz_d       = dz_q;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
`ifdef MULDIV_MTHI_EN
        if (WriteReq) begin
          if (WriteSel) hi_d = WriteData;
          else          lo_d = WriteData;
        end
`endif
        if (accept) begin
          op_d    = Op;
          a_d     = A;
          b_d     = B;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          dz_d    = (Op != OP_MULT) && (B == 32'd0);
          state_d = (Op == OP_MULT) ? S_MUL : S_DIV;
        end
      end

      S_MUL: begin
        if (cnt_q == MulLast) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_DIV: begin
        if (dz_q) begin
          // Zero divisor: single busy cycle, no iteration.
          hi_d       = a_q;
          lo_d       = 32'hFFFF_FFFF;
          div_zero_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          rem_d = sub_ok ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
          quo_d = {quo_q[30:0], sub_ok};
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_FIX: begin
        // Quotient sign follows operand sign mismatch, remainder follows dividend.
        lo_d    = ((op_q == OP_DIV) && (a_q[31] ^ b_q[31])) ? (-quo_q) : quo_q;
        hi_d    = ((op_q == OP_DIV) && a_q[31]) ? (-rem_q) : rem_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 2'b00;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign DivZero  = div_zero_q;
  assign ReadData = ReadSel ? hi_q : lo_q;
`ifdef MULDIV_MTHI_EN
  assign Stall    = Busy && (ReadReq || Start || WriteReq);
`else
  assign Stall    = Busy && (ReadReq || Start);
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (default build, MultCycles = 4).
module tb_muldiv_sequencer;

  logic        Clock, Reset, Start, ReadReq, ReadSel;
  logic [1:0]  Op;
  logic [31:0] A, B, ReadData;
  logic        Busy, Stall, DivZero;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Results captured by run_op / read_hilo.
  int          cyc;
  bit          stall_all;
  logic [31:0] rd_dat, hi, lo;
  logic        dz_end, dz_busy;

  muldiv_sequencer #(.MultCycles(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .ReadReq(ReadReq), .ReadSel(ReadSel), .ReadData(ReadData),
    .Busy(Busy), .Stall(Stall), .DivZero(DivZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Launch one op, count busy cycles, optionally read HI during Busy and/or hold Start.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rd, input bit hold);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = hold; ReadReq = rd; ReadSel = 1'b1;
    #1;
    rd_dat = ReadData;
    cyc = 0; stall_all = 1'b1; dz_busy = 1'b0;
    while (Busy && cyc < 200) begin
      cyc++;
      if (Stall !== 1'b1) stall_all = 1'b0;
      if (DivZero !== 1'b0) dz_busy = 1'b1;
      @(posedge Clock); #2;
    end
    dz_end = DivZero;
    ReadReq = 1'b0;
    if (!hold) Start = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL op_timeout busy=%0b required 0", Busy); end
  endtask

  task automatic read_hilo;
    ReadSel = 1'b1; #1; hi = ReadData;
    ReadSel = 1'b0; #1; lo = ReadData;
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start = 1'b0; Op = OP_MULT; A = '0; B = '0; ReadReq = 1'b0; ReadSel = 1'b0;
    #1 Reset = 1'b1;
    #12 ReadReq = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b required 0", Busy); end
    checks++; if (Stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got %0b required 0", Stall); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %0b required 0", DivZero); end
    read_hilo;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h required 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h required 0", lo); end
    ReadReq = 1'b0;
    @(negedge Clock); Reset = 1'b0;
  endtask

  task automatic test_mult;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    read_hilo;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_m1x0_hi got %h required 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mult_m1x0_lo got %h required 0", lo); end
    run_op(OP_MULT, 32'h1234_5678, 32'h0000_0100, 1'b0, 1'b0);
    read_hilo;
    checks++; if (hi !== 32'h0000_0012) begin errors++; $display("FAIL mult_shift_hi got %h required 00000012", hi); end
    checks++; if (lo !== 32'h3456_7800) begin errors++; $display("FAIL mult_shift_lo got %h required 34567800", lo); end
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    checks++; if (cyc != 4) begin errors++; $display("FAIL mult_busy_cycles got %0d required 4", cyc); end
    read_hilo;
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_m1x1_hi got %h required ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_m1x1_lo got %h required ffffffff", lo); end
  endtask

  task automatic test_divu;
    run_op(OP_DIVU, 32'd6, 32'd3, 1'b1, 1'b0);
    checks++; if (cyc != 33) begin errors++; $display("FAIL divu_busy_cycles got %0d required 33", cyc); end
    checks++; if (stall_all !== 1'b1) begin errors++; $display("FAIL divu_read_stall got %0b required 1", stall_all); end
    checks++; if (rd_dat !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_old_hi got %h required ffffffff", rd_dat); end
    read_hilo;
    checks++; if (lo !== 32'd2) begin errors++; $display("FAIL divu_6_3_lo got %h required 2", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divu_6_3_hi got %h required 0", hi); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
    read_hilo;
    checks++; if (lo !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_big_lo got %h required 0fffffff", lo); end
    checks++; if (hi !== 32'h0000_000F) begin errors++; $display("FAIL divu_big_hi got %h required 0000000f", hi); end
  endtask

  task automatic test_div;
    run_op(OP_DIV, 32'd11, 32'd3, 1'b0, 1'b0);
    checks++; if (cyc != 33) begin errors++; $display("FAIL div_busy_cycles got %0d required 33", cyc); end
    read_hilo;
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL div_11_3_lo got %h required 3", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_11_3_hi got %h required 2", hi); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    read_hilo;
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2_lo got %h required fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2_hi got %h required ffffffff", hi); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    read_hilo;
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo got %h required fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_7_m2_hi got %h required 1", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    read_hilo;
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_min_m1_lo got %h required 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_min_m1_hi got %h required 0", hi); end
  endtask

  task automatic test_div_zero;
    run_op(OP_DIV, 32'h1234, 32'd0, 1'b0, 1'b0);
    checks++; if (cyc != 1) begin errors++; $display("FAIL dz_busy_cycles got %0d required 1", cyc); end
    checks++; if (dz_busy !== 1'b0) begin errors++; $display("FAIL dz_early_pulse got %0b required 0", dz_busy); end
    checks++; if (dz_end !== 1'b1) begin errors++; $display("FAIL dz_pulse got %0b required 1", dz_end); end
    read_hilo;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL dz_hi got %h required 00001234", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h required ffffffff", lo); end
    @(posedge Clock); #1;
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL dz_pulse_width got %0b required 0", DivZero); end
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
    checks++; if (dz_end !== 1'b1) begin errors++; $display("FAIL dzu_pulse got %0b required 1", dz_end); end
    read_hilo;
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dzu_hi got %h required 5", hi); end
  endtask

  task automatic test_reserved_op;
    Op = OP_RSVD; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(posedge Clock); #1;
    checks++; if (Busy !== 1'b0)  begin errors++; $display("FAIL rsvd_busy got %0b required 0", Busy); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rsvd_stall got %0b required 0", Stall); end
    Start = 1'b0;
    read_hilo;
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL rsvd_hi got %h required 5", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rsvd_lo got %h required ffffffff", lo); end
  endtask

  task automatic test_start_and_read;
    int n;
    Op = OP_MULT; A = 32'd2; B = 32'd3; Start = 1'b1; ReadReq = 1'b1; ReadSel = 1'b0;
    #1;
    checks++; if (ReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sr_old_lo got %h required ffffffff", ReadData); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL sr_stall got %0b required 0", Stall); end
    @(posedge Clock); #1;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL sr_accept got %0b required 1", Busy); end
    Start = 1'b0; ReadReq = 1'b0;
    n = 0;
    while (Busy && n < 100) begin @(posedge Clock); #1; n++; end
    read_hilo;
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL sr_lo got %h required 6", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL sr_hi got %h required 0", hi); end
  endtask

  task automatic test_back_to_back;
    int n;
    run_op(OP_DIV, 32'd11, 32'd3, 1'b0, 1'b1);
    checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_busy_cycles got %0d required 33", cyc); end
    checks++; if (stall_all !== 1'b1) begin errors++; $display("FAIL b2b_stall got %0b required 1", stall_all); end
    // First IDLE cycle: first result visible, new operands presented with Start still high.
    A = 32'd100; B = 32'd7;
    read_hilo;
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL b2b_first_lo got %h required 3", lo); end
    @(posedge Clock); #1;
    Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %0b required 1", Busy); end
    n = 0;
    while (Busy && n < 100) begin @(posedge Clock); #1; n++; end
    read_hilo;
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_second_lo got %h required e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_second_hi got %h required 2", hi); end
  endtask

  task automatic test_reset_abort;
    Op = OP_DIVU; A = 32'd10; B = 32'd3; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got %0b required 0", Busy); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL abort_divzero got %0b required 0", DivZero); end
    read_hilo;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi got %h required 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo got %h required 0", lo); end
    @(negedge Clock); Reset = 1'b0;
    run_op(OP_DIVU, 32'd10, 32'd3, 1'b0, 1'b0);
    checks++; if (cyc != 33) begin errors++; $display("FAIL post_abort_cycles got %0d required 33", cyc); end
    read_hilo;
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL post_abort_lo got %h required 3", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL post_abort_hi got %h required 1", hi); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_divu;
    test_div;
    test_div_zero;
    test_reserved_op;
    test_start_and_read;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
